// File: rtl/ast_mux.sv
// Packet-atomic N:1 Avalon-ST merge with round-robin arbitration per packet.
// Ports: clk_i/rst_ni; snk_* (RX_DIR sinks); src_* (one registered source).
//   snk_data_i/channel_i/empty_i, sop/eop/valid_i in, snk_ready_o out per port.
//   src_data/channel/empty/sop/eop/valid_o out, src_ready_i in,
//   src_dir_o = index of the sink port that supplied the current beat.
module ast_mux #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 10,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int RX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [RX_DIR-1:0][DATA_WIDTH-1:0]     snk_data_i,
    input  logic [RX_DIR-1:0][CHANNEL_WIDTH-1:0]  snk_channel_i,
    input  logic [RX_DIR-1:0][EMPTY_WIDTH-1:0]    snk_empty_i,
    input  logic [RX_DIR-1:0]                     snk_startofpacket_i,
    input  logic [RX_DIR-1:0]                     snk_endofpacket_i,
    input  logic [RX_DIR-1:0]                     snk_valid_i,
    output logic [RX_DIR-1:0]                     snk_ready_o,
    output logic [DATA_WIDTH-1:0]                 src_data_o,
    output logic [CHANNEL_WIDTH-1:0]              src_channel_o,
    output logic [EMPTY_WIDTH-1:0]                src_empty_o,
    output logic                                  src_startofpacket_o,
    output logic                                  src_endofpacket_o,
    output logic                                  src_valid_o,
    input  logic                                  src_ready_i,
    output logic [DIR_SEL_WIDTH-1:0]              src_dir_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                   state_q;
    logic [DIR_SEL_WIDTH-1:0] grant_q;
    logic [DIR_SEL_WIDTH-1:0] last_grant_q;

    logic [DATA_WIDTH-1:0]    data_q;
    logic [CHANNEL_WIDTH-1:0] channel_q;
    logic [EMPTY_WIDTH-1:0]   empty_q;
    logic                     sop_q;
    logic                     eop_q;
    logic                     valid_q;
    logic [DIR_SEL_WIDTH-1:0] dir_q;

    logic                     out_free;
    logic                     accept;
    logic                     arb_any;
    logic [DIR_SEL_WIDTH-1:0] grant_d;
    logic [DIR_SEL_WIDTH-1:0] cand;
    int                       idx;

    // Output slot can take a beat if empty or being drained this cycle.
    assign out_free = ~valid_q | src_ready_i;
    assign accept   = (state_q == BUSY) & snk_valid_i[grant_q] & out_free;

    // Round-robin: first valid port after the last packet's owner, wrapping.
    always_comb begin
        arb_any = 1'b0;
        grant_d = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 1; i <= RX_DIR; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= RX_DIR) begin
                idx = idx - RX_DIR;
            end
            cand = DIR_SEL_WIDTH'(idx);
            if (!arb_any && snk_valid_i[cand]) begin
                arb_any = 1'b1;
                grant_d = cand;
            end
        end
    end

    always_comb begin
        snk_ready_o = '0;
        if (state_q == BUSY) begin
            snk_ready_o[grant_q] = out_free;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= DIR_SEL_WIDTH'(RX_DIR - 1);
            data_q       <= '0;
            channel_q    <= '0;
            empty_q      <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            valid_q      <= 1'b0;
            dir_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        grant_q <= grant_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant is held until the owner's eop beat is taken.
                    if (accept && snk_endofpacket_i[grant_q]) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end
                end
            endcase

            if (accept) begin
                data_q    <= snk_data_i[grant_q];
                channel_q <= snk_channel_i[grant_q];
                empty_q   <= snk_empty_i[grant_q];
                sop_q     <= snk_startofpacket_i[grant_q];
                eop_q     <= snk_endofpacket_i[grant_q];
                dir_q     <= grant_q;
                valid_q   <= 1'b1;
            end else if (out_free) begin
                valid_q   <= 1'b0;
            end
        end
    end

    assign src_data_o          = data_q;
    assign src_channel_o       = channel_q;
    assign src_empty_o         = empty_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o   = eop_q;
    assign src_valid_o         = valid_q;
    assign src_dir_o           = dir_q;

endmodule

// File: tb/tb_ast_mux.sv
// Bench for ast_mux: cycle tables for timing, hand sequences for reset
// and fairness, queue-driven sources for back-to-back streaming.
module tb_ast_mux;

    logic                  clk;
    logic                  rst_ni;
    logic [3:0][63:0]      snk_data;
    logic [3:0][9:0]       snk_channel;
    logic [3:0][2:0]       snk_empty;
    logic [3:0]            snk_sop;
    logic [3:0]            snk_eop;
    logic [3:0]            snk_valid;
    logic [3:0]            snk_ready;
    logic [63:0]           src_data;
    logic [9:0]            src_channel;
    logic [2:0]            src_empty;
    logic                  src_sop;
    logic                  src_eop;
    logic                  src_valid;
    logic                  src_ready;
    logic [1:0]            src_dir;

    int n_chk;
    int n_fail;

    ast_mux #(
        .DATA_WIDTH   (64),
        .CHANNEL_WIDTH(10),
        .EMPTY_WIDTH  (3),
        .RX_DIR       (4),
        .DIR_SEL_WIDTH(2)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .snk_data_i         (snk_data),
        .snk_channel_i      (snk_channel),
        .snk_empty_i        (snk_empty),
        .snk_startofpacket_i(snk_sop),
        .snk_endofpacket_i  (snk_eop),
        .snk_valid_i        (snk_valid),
        .snk_ready_o        (snk_ready),
        .src_data_o         (src_data),
        .src_channel_o      (src_channel),
        .src_empty_o        (src_empty),
        .src_startofpacket_o(src_sop),
        .src_endofpacket_o  (src_eop),
        .src_valid_o        (src_valid),
        .src_ready_i        (src_ready),
        .src_dir_o          (src_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  sop;
        logic [3:0]  eop;
        logic [31:0] d;
        logic [9:0]  chan;
        logic [2:0]  emp;
        logic        rdy;
        logic [3:0]  xrdy;
        logic        xv;
        logic [1:0]  xdir;
        logic [7:0]  xd;
        logic        xsop;
        logic        xeop;
        logic [9:0]  xchan;
        logic [2:0]  xemp;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct packed {
        logic [1:0] dir;
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } obeat_t;

    vec_t   vt[$];
    beat_t  pq[4][$];
    obeat_t exp_q[$];

    task automatic add(input vec_t v);
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        snk_data    = '0;
        snk_channel = '0;
        snk_empty   = '0;
        snk_sop     = '0;
        snk_eop     = '0;
        snk_valid   = '0;
    endtask

    // Called at posedge+1; the pulse stays clear of any clock edge.
    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic run_table();
        vec_t  v;
        string r;
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            r = $sformatf("row%0d", i);
            if (v.rst) do_reset();
            snk_valid = v.vld;
            snk_sop   = v.sop;
            snk_eop   = v.eop;
            src_ready = v.rdy;
            for (int p = 0; p < 4; p++) begin
                snk_data[p]    = {56'h0, v.d[8*p +: 8]};
                snk_channel[p] = v.chan + 10'(p);
                snk_empty[p]   = v.emp;
            end
            #1;
            chk({r, "_snk_ready"}, 64'(snk_ready), 64'(v.xrdy));
            step();
            chk({r, "_valid"}, 64'(src_valid), 64'(v.xv));
            if (v.xv) begin
                chk({r, "_data"}, src_data, {56'h0, v.xd});
                chk({r, "_dir"}, 64'(src_dir), 64'(v.xdir));
                chk({r, "_sop"}, 64'(src_sop), 64'(v.xsop));
                chk({r, "_eop"}, 64'(src_eop), 64'(v.xeop));
                chk({r, "_chan"}, 64'(src_channel), 64'(v.xchan));
                chk({r, "_empty"}, 64'(src_empty), 64'(v.xemp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] fire;
        obeat_t     e;
        beat_t      b;

        n_chk  = 0;
        n_fail = 0;

        // Test 1: port 2, three beats, latency 2 from first valid.
        add('{1'b1, 4'b0100, 4'b0100, 4'b0000, 32'h00A0_0000, 10'h100,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b0100, 4'b0100, 4'b0000, 32'h00A0_0000, 10'h100,
              3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA0, 1'b1, 1'b0,
              10'h102, 3'd0});
        add('{1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h00A1_0000, 10'h100,
              3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 1'b0, 1'b0,
              10'h102, 3'd0});
        add('{1'b0, 4'b0100, 4'b0000, 4'b0100, 32'h00A2_0000, 10'h100,
              3'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0, 1'b1,
              10'h102, 3'd2});
        add('{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 10'h100,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        // Test 4: port 3 single beat, empty 5, channel 2A5.
        add('{1'b0, 4'b1000, 4'b1000, 4'b1000, 32'hB500_0000, 10'h2A2,
              3'd5, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b1000, 4'b1000, 4'b1000, 32'hB500_0000, 10'h2A2,
              3'd5, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hB5, 1'b1, 1'b1,
              10'h2A5, 3'd5});
        add('{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        // Test 2: all ports, 2-beat packets, order 0..3 with bubbles.
        add('{1'b1, 4'b1111, 4'b1111, 4'b0000, 32'h3020_1000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b1111, 4'b1111, 4'b0000, 32'h3020_1000, 10'h000,
              3'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h00, 1'b1, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b1111, 4'b1110, 4'b0001, 32'h3020_1001, 10'h000,
              3'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01, 1'b0, 1'b1,
              10'h000, 3'd0});
        add('{1'b0, 4'b1110, 4'b1110, 4'b0000, 32'h3020_1000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b1110, 4'b1110, 4'b0000, 32'h3020_1000, 10'h000,
              3'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h10, 1'b1, 1'b0,
              10'h001, 3'd0});
        add('{1'b0, 4'b1110, 4'b1100, 4'b0010, 32'h3020_1100, 10'h000,
              3'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0, 1'b1,
              10'h001, 3'd0});
        add('{1'b0, 4'b1100, 4'b1100, 4'b0000, 32'h3020_0000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b1100, 4'b1100, 4'b0000, 32'h3020_0000, 10'h000,
              3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h20, 1'b1, 1'b0,
              10'h002, 3'd0});
        add('{1'b0, 4'b1100, 4'b1000, 4'b0100, 32'h3021_0000, 10'h000,
              3'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h21, 1'b0, 1'b1,
              10'h002, 3'd0});
        add('{1'b0, 4'b1000, 4'b1000, 4'b0000, 32'h3000_0000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b1000, 4'b1000, 4'b0000, 32'h3000_0000, 10'h000,
              3'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h30, 1'b1, 1'b0,
              10'h003, 3'd0});
        add('{1'b0, 4'b1000, 4'b0000, 4'b1000, 32'h3100_0000, 10'h000,
              3'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h31, 1'b0, 1'b1,
              10'h003, 3'd0});
        add('{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        // Test 3: port 1, 4 beats, src_ready toggling 1,0,1,0...
        add('{1'b1, 4'b0010, 4'b0010, 4'b0000, 32'h0000_4000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});
        add('{1'b0, 4'b0010, 4'b0010, 4'b0000, 32'h0000_4000, 10'h000,
              3'd0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h40, 1'b1, 1'b0,
              10'h001, 3'd0});
        add('{1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h0000_4100, 10'h000,
              3'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h41, 1'b0, 1'b0,
              10'h001, 3'd0});
        add('{1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h0000_4200, 10'h000,
              3'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h41, 1'b0, 1'b0,
              10'h001, 3'd0});
        add('{1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h0000_4200, 10'h000,
              3'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h42, 1'b0, 1'b0,
              10'h001, 3'd0});
        add('{1'b0, 4'b0010, 4'b0000, 4'b0010, 32'h0000_4300, 10'h000,
              3'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h42, 1'b0, 1'b0,
              10'h001, 3'd0});
        add('{1'b0, 4'b0010, 4'b0000, 4'b0010, 32'h0000_4300, 10'h000,
              3'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h43, 1'b0, 1'b1,
              10'h001, 3'd0});
        add('{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 10'h000,
              3'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h43, 1'b0, 1'b1,
              10'h001, 3'd0});
        add('{1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 10'h000,
              3'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0,
              10'h000, 3'd0});

        // Reset state.
        clear_inputs();
        src_ready = 1'b0;
        rst_ni    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(src_valid), 64'd0);
        chk("rst_data", src_data, 64'd0);
        chk("rst_chan", 64'(src_channel), 64'd0);
        chk("rst_empty", 64'(src_empty), 64'd0);
        chk("rst_sop", 64'(src_sop), 64'd0);
        chk("rst_eop", 64'(src_eop), 64'd0);
        chk("rst_dir", 64'(src_dir), 64'd0);
        chk("rst_snk_ready", 64'(snk_ready), 64'd0);
        rst_ni = 1'b1;

        run_table();

        // Test 5: reset in the middle of a port-2 packet.
        do_reset();
        clear_inputs();
        src_ready    = 1'b1;
        snk_valid[2] = 1'b1;
        snk_sop[2]   = 1'b1;
        snk_data[2]  = 64'h70;
        step();
        step();
        snk_sop[2]   = 1'b0;
        snk_data[2]  = 64'h71;
        step();
        chk("t5_pre_valid", 64'(src_valid), 64'd1);
        chk("t5_pre_data", src_data, 64'h71);
        chk("t5_pre_dir", 64'(src_dir), 64'd2);
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(src_valid), 64'd0);
        chk("t5_rst_data", src_data, 64'd0);
        chk("t5_rst_dir", 64'(src_dir), 64'd0);
        chk("t5_rst_sop", 64'(src_sop), 64'd0);
        chk("t5_rst_snk_ready", 64'(snk_ready), 64'd0);
        #1;
        rst_ni = 1'b1;
        clear_inputs();
        snk_valid   = 4'b0101;
        snk_sop     = 4'b0101;
        snk_eop     = 4'b0101;
        snk_data[0] = 64'h50;
        snk_data[2] = 64'h60;
        step();
        chk("t5_arb_bubble", 64'(src_valid), 64'd0);
        step();
        chk("t5_first_valid", 64'(src_valid), 64'd1);
        chk("t5_first_dir", 64'(src_dir), 64'd0);
        chk("t5_first_data", src_data, 64'h50);
        snk_valid[0] = 1'b0;
        step();
        chk("t5_gap_valid", 64'(src_valid), 64'd0);
        step();
        chk("t5_second_valid", 64'(src_valid), 64'd1);
        chk("t5_second_dir", 64'(src_dir), 64'd2);
        chk("t5_second_data", src_data, 64'h60);
        clear_inputs();
        step();

        // Test 6: port 1 streams two packets while port 3 waits with one.
        do_reset();
        clear_inputs();
        src_ready = 1'b1;
        pq[1].push_back('{8'h81, 1'b1, 1'b0});
        pq[1].push_back('{8'h82, 1'b0, 1'b1});
        pq[1].push_back('{8'h83, 1'b1, 1'b0});
        pq[1].push_back('{8'h84, 1'b0, 1'b1});
        pq[3].push_back('{8'h91, 1'b1, 1'b0});
        pq[3].push_back('{8'h92, 1'b0, 1'b1});
        exp_q.push_back('{2'd1, 8'h81, 1'b1, 1'b0});
        exp_q.push_back('{2'd1, 8'h82, 1'b0, 1'b1});
        exp_q.push_back('{2'd3, 8'h91, 1'b1, 1'b0});
        exp_q.push_back('{2'd3, 8'h92, 1'b0, 1'b1});
        exp_q.push_back('{2'd1, 8'h83, 1'b1, 1'b0});
        exp_q.push_back('{2'd1, 8'h84, 1'b0, 1'b1});
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (pq[p].size() > 0) begin
                    snk_valid[p] = 1'b1;
                    snk_data[p]  = {56'h0, pq[p][0].d};
                    snk_sop[p]   = pq[p][0].sop;
                    snk_eop[p]   = pq[p][0].eop;
                end else begin
                    snk_valid[p] = 1'b0;
                    snk_sop[p]   = 1'b0;
                    snk_eop[p]   = 1'b0;
                end
            end
            @(negedge clk);
            fire = snk_valid & snk_ready;
            if (src_valid && src_ready) begin
                e = exp_q.pop_front();
                chk($sformatf("t6_dir_%0h", e.d), 64'(src_dir),
                    64'(e.dir));
                chk($sformatf("t6_data_%0h", e.d), src_data,
                    {56'h0, e.d});
                chk($sformatf("t6_sop_%0h", e.d), 64'(src_sop),
                    64'(e.sop));
                chk($sformatf("t6_eop_%0h", e.d), 64'(src_eop),
                    64'(e.eop));
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                if (fire[p]) b = pq[p].pop_front();
            end
        end
        chk("t6_beats_left", 64'(exp_q.size()), 64'd0);
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
